// File: rtl/z_serial_capture.sv
// Bit-serial capture stage: drives the upstream 2:1 mux select and shifts WIDTH
// mux bits MSB-first into a word with a valid/ack handshake. Optional macro: Z_CAPTURE_PARITY_EN.
module z_serial_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             src,
    input  logic             din,
    input  logic             ack,
    output logic             sel,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             perr
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic             sel_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == SHIFT) && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count_q == LAST) begin
`ifdef Z_CAPTURE_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = DONE;
`endif
                end
            end
            PARITY: begin
`ifdef Z_CAPTURE_PARITY_EN
                busy    = 1'b1;
                state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                valid = 1'b1;
                // ack wins over a simultaneous start; the start is dropped, not queued
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel only moves on an accepted start so the mux output is stable for the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            sel_q   <= src;
            data_q  <= '0;
            count_q <= '0;
        end else if (state_q == SHIFT) begin
            data_q <= {data_q[WIDTH-2:0], din};
            if (!last_bit) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

`ifdef Z_CAPTURE_PARITY_EN
    logic perr_q;

    // even parity over the captured word plus the trailing parity bit
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (accept) begin
            perr_q <= 1'b0;
        end else if (state_q == PARITY) begin
            perr_q <= (^data_q) ^ din;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign sel  = sel_q;
    assign data = data_q;

endmodule
